mem_port_arbiter: RTL and testbench

// Shares one synchronous memory port between the instruction-fetch requester (port 0, read-only)
// and the core data-memory requester (port 1, read/write with byte enables).

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and port ids for mem_port_arbiter
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // A lone requester wins outright; on conflict the port not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == PORT_IFETCH) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ifetch_req,
  input  logic [ADDR_WIDTH-1:0]   ifetch_address,
  output logic                    ifetch_gnt,
  output logic                    ifetch_rvalid,
  output logic [DATA_WIDTH-1:0]   ifetch_rdata,
  input  logic                    data_req,
  input  logic                    data_write,
  input  logic [ADDR_WIDTH-1:0]   data_address,
  input  logic [DATA_WIDTH-1:0]   data_write_data,
  input  logic [DATA_WIDTH/8-1:0] data_byte_enable,
  output logic                    data_gnt,
  output logic                    data_rvalid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    busy
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

  arb_state_t state, state_next;
  logic [2:0] lat_cnt, lat_cnt_next;
  logic       owner, owner_next;
  logic       last_gnt, last_gnt_next;
  logic       can_issue;
  logic       read_done;
  logic       issue_read;
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;

  // The last cycle of an outstanding read doubles as an issue slot so
  // single-cycle latency can sustain one read per cycle.
  assign can_issue = (state == ARB_IDLE) || ((state == ARB_WAIT) && (lat_cnt == 3'd1));
  assign read_done = (state == ARB_WAIT) && (lat_cnt == 3'd1) && !reset;
  assign arb_req   = {data_req, ifetch_req} & {2{can_issue && !reset}};
  assign busy      = (state == ARB_WAIT);

  rr_arbiter2 u_rr (
    .req      (arb_req),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt)
  );

  // State, latency counter, read owner and fairness history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ARB_IDLE;
      lat_cnt  <= 3'd0;
      owner    <= PORT_IFETCH;
      last_gnt <= PORT_IFETCH;
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_cnt_next;
      owner    <= owner_next;
      last_gnt <= last_gnt_next;
    end
  end

  // Next state, grants, memory mux and read-return routing.
  always_comb begin
    state_next       = state;
    lat_cnt_next     = lat_cnt;
    owner_next       = owner;
    last_gnt_next    = last_gnt;
    ifetch_gnt       = arb_gnt[0];
    data_gnt         = arb_gnt[1];
    ifetch_rvalid    = 1'b0;
    ifetch_rdata     = '0;
    data_rvalid      = 1'b0;
    data_rdata       = '0;
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    issue_read       = arb_gnt[0] || (arb_gnt[1] && !data_write);

    if (arb_gnt[0]) begin
      mem_address     = ifetch_address;
      mem_read_enable = 1'b1;
      mem_byte_enable = '1;
    end else if (arb_gnt[1]) begin
      mem_address      = data_address;
      mem_read_enable  = !data_write;
      mem_write_enable = data_write;
      mem_write_data   = data_write ? data_write_data : '0;
      mem_byte_enable  = data_write ? data_byte_enable : '1;
    end

    if (arb_gnt != 2'b00) begin
      last_gnt_next = arb_gnt[1];
    end

    if (state == ARB_WAIT) begin
      lat_cnt_next = lat_cnt - 3'd1;
      if (lat_cnt == 3'd1) begin
        state_next = ARB_IDLE;
      end
    end

    if (issue_read) begin
      state_next   = ARB_WAIT;
      lat_cnt_next = LAT_LOAD;
      owner_next   = arb_gnt[1];
    end

    if (read_done) begin
      if (owner == PORT_IFETCH) begin
        ifetch_rvalid = 1'b1;
        ifetch_rdata  = mem_read_data;
      end else begin
        data_rvalid = 1'b1;
        data_rdata  = mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clock;

  // Lane 0 drives a READ_LATENCY=1 instance, lane 1 a READ_LATENCY=3 instance.
  logic [1:0]       rst, if_req, if_gnt, if_rv, d_req, d_wr, d_gnt, d_rv, m_re, m_we, busy;
  logic [1:0][31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0][3:0]  d_be, m_be;

  int lat [2] = '{1, 3};

  logic [31:0] envmem    [2][256];
  logic [31:0] shadow    [2][256];
  logic [31:0] env_slot  [2][8];
  bit          env_v     [2][8];
  bit          pend_v    [2];
  int          pend_due  [2];
  bit          pend_port [2];
  logic [31:0] pend_data [2];
  bit          last_w    [2];
  bit          mg_if     [2];
  bit          mg_d      [2];

  int cyc;
  int n_checks;
  int n_fail;
  int p_req, p_drop, p_wr, p_rst;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(rst[0]),
    .ifetch_req(if_req[0]), .ifetch_address(if_addr[0]), .ifetch_gnt(if_gnt[0]),
    .ifetch_rvalid(if_rv[0]), .ifetch_rdata(if_rdata[0]),
    .data_req(d_req[0]), .data_write(d_wr[0]), .data_address(d_addr[0]),
    .data_write_data(d_wdata[0]), .data_byte_enable(d_be[0]), .data_gnt(d_gnt[0]),
    .data_rvalid(d_rv[0]), .data_rdata(d_rdata[0]),
    .mem_address(m_addr[0]), .mem_read_enable(m_re[0]), .mem_write_enable(m_we[0]),
    .mem_write_data(m_wdata[0]), .mem_byte_enable(m_be[0]), .mem_read_data(m_rdata[0]),
    .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut_l3 (
    .clock(clock), .reset(rst[1]),
    .ifetch_req(if_req[1]), .ifetch_address(if_addr[1]), .ifetch_gnt(if_gnt[1]),
    .ifetch_rvalid(if_rv[1]), .ifetch_rdata(if_rdata[1]),
    .data_req(d_req[1]), .data_write(d_wr[1]), .data_address(d_addr[1]),
    .data_write_data(d_wdata[1]), .data_byte_enable(d_be[1]), .data_gnt(d_gnt[1]),
    .data_rvalid(d_rv[1]), .data_rdata(d_rdata[1]),
    .mem_address(m_addr[1]), .mem_read_enable(m_re[1]), .mem_write_enable(m_we[1]),
    .mem_write_data(m_wdata[1]), .mem_byte_enable(m_be[1]), .mem_read_data(m_rdata[1]),
    .busy(busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int l, input string n);
    return $sformatf("lat%0d cyc%0d %s", lat[l], cyc, n);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] raddr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  // Reference: a read granted at cycle c returns at c+latency; a new grant is
  // possible whenever nothing is pending or the pending read returns now.
  task automatic check_lane(input int l);
    logic        eg_if, eg_d, due, wr_g, rd_g;
    logic [31:0] ga;
    eg_if = 1'b0;
    eg_d  = 1'b0;
    ga    = 32'h0;
    due   = pend_v[l] && (pend_due[l] == cyc);
    if (rst[l]) begin
      check_eq(tg(l, "rst if_gnt"), 32'(if_gnt[l]), 32'h0);
      check_eq(tg(l, "rst d_gnt"), 32'(d_gnt[l]), 32'h0);
      check_eq(tg(l, "rst if_rvalid"), 32'(if_rv[l]), 32'h0);
      check_eq(tg(l, "rst d_rvalid"), 32'(d_rv[l]), 32'h0);
      check_eq(tg(l, "rst mem_re"), 32'(m_re[l]), 32'h0);
      check_eq(tg(l, "rst mem_we"), 32'(m_we[l]), 32'h0);
      pend_v[l] = 1'b0;
      last_w[l] = 1'b0;
      mg_if[l]  = 1'b0;
      mg_d[l]   = 1'b0;
      return;
    end
    if (!pend_v[l] || due) begin
      if (if_req[l] && d_req[l]) begin
        if (last_w[l]) eg_if = 1'b1;
        else eg_d = 1'b1;
      end else if (d_req[l]) eg_d = 1'b1;
      else if (if_req[l]) eg_if = 1'b1;
    end
    wr_g = eg_d && d_wr[l];
    rd_g = eg_if || (eg_d && !d_wr[l]);
    check_eq(tg(l, "if_gnt"), 32'(if_gnt[l]), 32'(eg_if));
    check_eq(tg(l, "d_gnt"), 32'(d_gnt[l]), 32'(eg_d));
    check_eq(tg(l, "if_rvalid"), 32'(if_rv[l]), 32'(due && !pend_port[l]));
    check_eq(tg(l, "d_rvalid"), 32'(d_rv[l]), 32'(due && pend_port[l]));
    check_eq(tg(l, "if_rdata"), if_rdata[l], (due && !pend_port[l]) ? pend_data[l] : 32'h0);
    check_eq(tg(l, "d_rdata"), d_rdata[l], (due && pend_port[l]) ? pend_data[l] : 32'h0);
    check_eq(tg(l, "busy"), 32'(busy[l]), 32'(pend_v[l]));
    check_eq(tg(l, "mem_re"), 32'(m_re[l]), 32'(rd_g));
    check_eq(tg(l, "mem_we"), 32'(m_we[l]), 32'(wr_g));
    if (eg_if || eg_d) begin
      ga = eg_if ? if_addr[l] : d_addr[l];
      check_eq(tg(l, "mem_addr"), m_addr[l], ga);
      check_eq(tg(l, "mem_be"), 32'(m_be[l]), wr_g ? 32'(d_be[l]) : 32'hF);
      if (wr_g) check_eq(tg(l, "mem_wdata"), m_wdata[l], d_wdata[l]);
    end
    // memory environment reacts to what the DUT actually drives
    if (m_re[l]) begin
      env_slot[l][(cyc + lat[l]) & 7] = envmem[l][m_addr[l][9:2]];
      env_v[l][(cyc + lat[l]) & 7]    = 1'b1;
    end
    if (m_we[l]) envmem[l][m_addr[l][9:2]] = merge(envmem[l][m_addr[l][9:2]], m_wdata[l], m_be[l]);
    // reference model update
    if (due) pend_v[l] = 1'b0;
    if (rd_g) begin
      pend_v[l]    = 1'b1;
      pend_due[l]  = cyc + lat[l];
      pend_port[l] = eg_d;
      pend_data[l] = shadow[l][ga[9:2]];
    end
    if (wr_g) shadow[l][ga[9:2]] = merge(shadow[l][ga[9:2]], d_wdata[l], d_be[l]);
    if (eg_if || eg_d) last_w[l] = eg_d;
    mg_if[l] = eg_if;
    mg_d[l]  = eg_d;
  endtask

  task automatic tick();
    @(negedge clock);
    check_lane(0);
    check_lane(1);
    @(posedge clock);
    #1;
    cyc++;
    for (int l = 0; l < 2; l++) begin
      if (env_v[l][cyc & 7]) m_rdata[l] = env_slot[l][cyc & 7];
      else m_rdata[l] = $urandom;
      env_v[l][cyc & 7] = 1'b0;
    end
  endtask

  task automatic rand_drive(input int l);
    bit g;
    g = mg_if[l];
    if (if_req[l] && !g && ($urandom_range(0, 99) < p_drop)) if_req[l] = 1'b0;
    else if (!if_req[l] || g) begin
      if ($urandom_range(0, 99) < p_req) begin
        if_req[l]  = 1'b1;
        if_addr[l] = raddr();
      end else if_req[l] = 1'b0;
    end
    g = mg_d[l];
    if (d_req[l] && !g && ($urandom_range(0, 99) < p_drop)) d_req[l] = 1'b0;
    else if (!d_req[l] || g) begin
      if ($urandom_range(0, 99) < p_req) begin
        d_req[l]   = 1'b1;
        d_wr[l]    = ($urandom_range(0, 99) < p_wr);
        d_addr[l]  = raddr();
        d_wdata[l] = $urandom;
        d_be[l]    = 4'($urandom_range(0, 15));
      end else d_req[l] = 1'b0;
    end
    rst[l] = ($urandom_range(0, 999) < p_rst);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 256; i++) begin
        envmem[l][i] = $urandom;
        shadow[l][i] = envmem[l][i];
      end
      envmem[l][64] = 32'hDEADBEEF;
      shadow[l][64] = 32'hDEADBEEF;
      for (int s = 0; s < 8; s++) env_v[l][s] = 1'b0;
      pend_v[l] = 1'b0;
      last_w[l] = 1'b0;
      mg_if[l]  = 1'b0;
      mg_d[l]   = 1'b0;
    end
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
    rst = 2'b11; if_req = 2'b11; d_req = 2'b11; d_wr = 2'b11;
    repeat (2) tick();

    rst = 2'b00; if_req = 2'b00; d_req = 2'b00; d_wr = 2'b00;
    repeat (10) tick();

    // single fetch at latency 1
    if_req[0] = 1'b1; if_addr[0] = 32'h100; #2;
    check_eq("fetch gnt", 32'(if_gnt[0]), 32'h1);
    check_eq("fetch mem_addr", m_addr[0], 32'h100);
    tick();
    if_req[0] = 1'b0; #2;
    check_eq("fetch rvalid", 32'(if_rv[0]), 32'h1);
    check_eq("fetch rdata", if_rdata[0], 32'hDEADBEEF);
    tick();

    // idle write completes in its grant cycle
    d_req[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'h55AA00FF; d_be[0] = 4'b0011; #2;
    check_eq("write gnt", 32'(d_gnt[0]), 32'h1);
    check_eq("write mem_we", 32'(m_we[0]), 32'h1);
    check_eq("write mem_be", 32'(m_be[0]), 32'h3);
    check_eq("write mem_wdata", m_wdata[0], 32'h55AA00FF);
    check_eq("write busy", 32'(busy[0]), 32'h0);
    tick();
    d_req[0] = 1'b0; d_wr[0] = 1'b0; #2;
    check_eq("write busy after", 32'(busy[0]), 32'h0);
    tick();

    // back-to-back data reads at latency 1
    for (int i = 0; i < 3; i++) begin
      d_req[0] = 1'b1; d_addr[0] = 32'(4 * i); #2;
      check_eq($sformatf("b2b gnt %0d", i), 32'(d_gnt[0]), 32'h1);
      check_eq($sformatf("b2b addr %0d", i), m_addr[0], 32'(4 * i));
      if (i > 0) begin
        check_eq($sformatf("b2b rvalid %0d", i - 1), 32'(d_rv[0]), 32'h1);
        check_eq($sformatf("b2b rdata %0d", i - 1), d_rdata[0], shadow[0][i - 1]);
      end
      tick();
    end
    d_req[0] = 1'b0; #2;
    check_eq("b2b rvalid 2", 32'(d_rv[0]), 32'h1);
    check_eq("b2b rdata 2", d_rdata[0], shadow[0][2]);
    tick();

    // latency 3: reset one cycle after grant drops the read
    if_req[1] = 1'b1; if_addr[1] = 32'h200; #2;
    check_eq("lat3 gnt", 32'(if_gnt[1]), 32'h1);
    tick();
    if_req[1] = 1'b0; rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    tick();
    #2;
    check_eq("lat3 dropped rvalid", 32'(if_rv[1]), 32'h0);
    check_eq("lat3 busy", 32'(busy[1]), 32'h0);
    tick();

    // continuous contention straight after reset: data first, then alternate
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = raddr();
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = raddr(); #2;
    check_eq("first conflict data gnt", 32'(d_gnt[0]), 32'h1);
    check_eq("first conflict if gnt", 32'(if_gnt[0]), 32'h0);
    p_req = 100; p_drop = 0; p_wr = 0; p_rst = 0;
    repeat (24) begin
      tick();
      rand_drive(0);
    end

    // random traffic on both lanes
    p_req = 85; p_drop = 5; p_wr = 30; p_rst = 3;
    repeat (1500) begin
      tick();
      rand_drive(0);
      rand_drive(1);
    end
    p_req = 30; p_drop = 15; p_wr = 40; p_rst = 5;
    repeat (1500) begin
      tick();
      rand_drive(0);
      rand_drive(1);
    end
    rst = 2'b00; if_req = 2'b00; d_req = 2'b00;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
